alu_req_arbiter: RTL and testbench

//  Shares one ALU16Bit between NREQ requesters. Each requester presents op/a/b with a valid/ready handshake.
//  The block arbitrates, drives the ALU from registered operands, and returns result+flags+tag on one response channel.

---
 rtl/alu_arb_pkg.sv | 36 +++
 rtl/alu_arb_pick.sv | 42 ++++
 rtl/alu_req_arbiter.sv | 117 +++++++++++
 tb/tb_alu_req_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM states, ALU op codes, flag positions.
// Pure declarations, so there is no latency and no backpressure here.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int FLAG_COUT = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } alu_req_t;

  function automatic logic [2:0] pack_flags(input logic cout, input logic ovf, input logic zero);
    logic [2:0] f;
    f            = '0;
    f[FLAG_COUT] = cout;
    f[FLAG_OVF]  = ovf;
    f[FLAG_ZERO] = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select: round-robin from ptr with ALU_ARB_RR_EN, otherwise lowest index wins.
// Zero latency; no backpressure, grant is one-hot or zero and only ever covers a valid requester.
module alu_arb_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] valid,
`ifdef ALU_ARB_RR_EN
  input  logic [IDXW-1:0] ptr,
`endif
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
`ifdef ALU_ARB_RR_EN
    // Walk NREQ slots starting at ptr; the first valid one wins.
    for (int k = 0; k < NREQ; k++) begin
      if (!any && valid[(int'(ptr) + k) % NREQ]) begin
        any                              = 1'b1;
        grant[(int'(ptr) + k) % NREQ]    = 1'b1;
        idx                              = IDXW'((int'(ptr) + k) % NREQ);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDXW'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU16Bit among NREQ requesters; accept at T gives rsp_valid at T+2, one op in flight.
// Response held until rsp_ready; requests are only granted in IDLE or on the RESP handshake. ALU_ARB_RR_EN selects round-robin.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_cin,
  input  logic [15:0]        alu_result,
  input  logic               alu_cout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_result,
  output logic [2:0]         rsp_flags,
  output logic [TAGW-1:0]    rsp_tag
);

  localparam int IDXW = $clog2(NREQ);

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic            take;
  logic            accept;
  alu_req_t        win_req;

`ifdef ALU_ARB_RR_EN
  logic [IDXW-1:0] rr_ptr;

  alu_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );
`else
  alu_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .valid (req_valid),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );
`endif

  // A grant slot exists in IDLE, or in RESP on the cycle the response is consumed.
  assign take      = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign accept    = take && win_any;
  assign req_ready = take ? grant : '0;
  assign alu_cin   = alu_op[2];

  always_comb begin
    win_req    = '0;
    win_req.op = req_op[3*win_idx +: 3];
    win_req.a  = req_a[16*win_idx +: 16];
    win_req.b  = req_b[16*win_idx +: 16];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr     <= '0;
`endif
    end else begin
      if (accept) begin
        alu_op  <= win_req.op;
        alu_a   <= win_req.a;
        alu_b   <= win_req.b;
        rsp_tag <= TAGW'(win_idx);
`ifdef ALU_ARB_RR_EN
        rr_ptr  <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
`endif
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= pack_flags(alu_cout, alu_overflow, alu_zero);
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= win_any ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU16Bit model; expectations follow ALU_ARB_RR_EN.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_cout, alu_overflow, alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [1:0]  rsp_tag;

  int checks   = 0;
  int failures = 0;

  alu_req_arbiter #(.NREQ(4), .TAGW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_tag      (rsp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU16Bit: op[2] inverts b, add/sub path shared with SLT.
  logic [15:0] m_bb;
  logic [16:0] m_sum;
  logic        m_ovf;
  always_comb begin
    m_bb         = alu_op[2] ? ~alu_b : alu_b;
    m_sum        = {1'b0, alu_a} + {1'b0, m_bb} + {16'b0, alu_cin};
    m_ovf        = (alu_a[15] == m_bb[15]) && (m_sum[15] != alu_a[15]);
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op[1:0])
      2'b00: alu_result = alu_a & alu_b;
      2'b01: alu_result = alu_a | alu_b;
      2'b10: begin
        alu_result   = m_sum[15:0];
        alu_cout     = m_sum[16];
        alu_overflow = m_ovf;
      end
      default: begin
        alu_result   = {15'b0, m_sum[15] ^ m_ovf};
        alu_cout     = m_sum[16];
        alu_overflow = m_ovf;
      end
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  typedef struct {
    int          idx;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[3*idx +: 3]  = op;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    set_req(v.idx, v.op, v.a, v.b);
    req_valid = onehot(v.idx);
    #1;
    chk("vec_grant", req_ready, onehot(v.idx));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("vec_exec_rsp_valid", rsp_valid, 0);
    chk("vec_alu_cin", alu_cin, v.op[2]);
    chk("vec_alu_a", alu_a, v.a);
    @(negedge clk);
    #1;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_result", rsp_result, v.res);
    chk("vec_rsp_flags", rsp_flags, v.flg);
    chk("vec_rsp_tag", rsp_tag, v.idx);
  endtask

  int exp_tag[5];

  initial begin
    // idx, op, a, b, result, flags {cout, ovf, zero}
    vecs[0] = '{0, OP_ADD, 16'h0003, 16'h0004, 16'h0007, 3'b000};
    vecs[1] = '{1, OP_SUB, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b010};
    vecs[2] = '{2, OP_SUB, 16'h1234, 16'h1234, 16'h0000, 3'b101};
    vecs[3] = '{3, OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 3'b000};
    vecs[4] = '{0, OP_SLT, 16'h0005, 16'h0009, 16'h0001, 3'b000};
    vecs[5] = '{1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b101};
`ifdef ALU_ARB_RR_EN
    exp_tag = '{0, 1, 2, 3, 0};
`else
    exp_tag = '{0, 0, 0, 0, 0};
`endif

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_cin", alu_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fresh reset so the round-robin pointer starts at 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters valid continuously with rsp_ready=1.
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 16'(i * 256), 16'h0001);
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k % 2 == 0) chk("stream_grant", req_ready, onehot(exp_tag[k/2]));
      else            chk("stream_exec_ready", req_ready, 0);
      if (k >= 2 && k % 2 == 0) begin
        chk("stream_rsp_valid", rsp_valid, 1);
        chk("stream_rsp_tag", rsp_tag, exp_tag[k/2-1]);
        chk("stream_rsp_result", rsp_result, 32'(exp_tag[k/2-1] * 256 + 1));
      end
      @(negedge clk);
    end
    req_valid = '0;

    // Response backpressure with a pending requester.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(3, OP_OR, 16'h00F0, 16'h0F00);
    req_valid = 4'b1000;
    #1;
    chk("bp_grant", req_ready, 4'b1000);
    @(negedge clk);
    set_req(0, OP_ADD, 16'h0001, 16'h0001);
    req_valid = 4'b0001;
    #1;
    chk("bp_exec_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 16'h0FF0);
      chk("bp_rsp_tag", rsp_tag, 3);
      chk("bp_req_ready", req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b0001);
    chk("bp_release_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("bp_next_exec", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("bp_next_rsp_valid", rsp_valid, 1);
    chk("bp_next_result", rsp_result, 16'h0002);
    chk("bp_next_tag", rsp_tag, 0);

    // Reset while an op is executing.
    @(negedge clk);
    set_req(1, OP_ADD, 16'h0010, 16'h0020);
    req_valid = 4'b0010;
    #1;
    chk("mid_rst_grant", req_ready, 4'b0010);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    set_req(0, OP_ADD, 16'h0005, 16'h0006);
    req_valid = 4'b1011;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("post_rst_no_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_tag", rsp_tag, 0);
    chk("post_rst_result", rsp_result, 16'h000B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
